// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory: RAM control word layout,
// access size codes and fault cause codes.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;

    localparam int unsigned CTRL_E       = 3;
    localparam int unsigned CTRL_RW      = 2;
    localparam int unsigned CTRL_SIZE_HI = 1;
    localparam int unsigned CTRL_SIZE_LO = 0;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10,
        FC_SIZE     = 2'b11
    } cause_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering for one access inside an aligned 32-bit word:
// byte enables, store lane replication, load extraction and size/alignment flags.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e              size_i,
    input  logic [1:0]         offs_i,
    input  logic [DATA_W-1:0]  st_data_i,
    input  logic [DATA_W-1:0]  ld_word_i,
    output logic [LANES-1:0]   be_o,
    output logic [DATA_W-1:0]  st_lanes_o,
    output logic [DATA_W-1:0]  ld_data_o,
    output logic               misalign_o,
    output logic               rsvd_o
);

    // Lane 3 is bits 31:24 (lowest byte address), lane 0 is bits 7:0.
    always_comb begin
        be_o       = '0;
        st_lanes_o = '0;
        ld_data_o  = '0;
        misalign_o = 1'b0;
        rsvd_o     = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o       = 4'b1000 >> offs_i;
                st_lanes_o = {4{st_data_i[7:0]}};
                case (offs_i)
                    2'd0:    ld_data_o = {24'b0, ld_word_i[31:24]};
                    2'd1:    ld_data_o = {24'b0, ld_word_i[23:16]};
                    2'd2:    ld_data_o = {24'b0, ld_word_i[15:8]};
                    default: ld_data_o = {24'b0, ld_word_i[7:0]};
                endcase
            end
            SZ_HALF: begin
                misalign_o = offs_i[0];
                be_o       = offs_i[1] ? 4'b0011 : 4'b1100;
                st_lanes_o = {2{st_data_i[15:0]}};
                ld_data_o  = offs_i[1] ? {16'b0, ld_word_i[15:0]}
                                       : {16'b0, ld_word_i[31:16]};
            end
            SZ_WORD: begin
                misalign_o = |offs_i;
                be_o       = 4'b1111;
                st_lanes_o = st_data_i;
                ld_data_o  = ld_word_i;
            end
            default: begin
                rsvd_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage byte-addressed data memory: zero-latency loads, edge-written stores,
// and a sticky first-fault record for debug/exception logic.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [DATA_W-1:0]  MEM_ALU_OUT_in,
    input  logic [DATA_W-1:0]  MEM_RB_in,
    input  logic [3:0]         MEM_RAM_CTRL_in,
    output logic [DATA_W-1:0]  MEM_DATA_out,
    output logic               MEM_FAULT_out,
    output logic [DATA_W-1:0]  MEM_FAULT_ADDR_out,
    output logic [1:0]         MEM_FAULT_CAUSE_out
);

    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam int unsigned WIDX_W = ADDR_BITS - 2;

    logic [7:0] mem_q [DEPTH];

    logic               en;
    logic               rw;
    size_e              size;
    logic [WIDX_W-1:0]  widx;
    logic [DATA_W-1:0]  ld_word;
    logic [LANES-1:0]   be;
    logic [DATA_W-1:0]  st_lanes;
    logic [DATA_W-1:0]  ld_data;
    logic               misalign;
    logic               rsvd;
    logic               out_of_range;
    logic               illegal;
    logic               legal;
    cause_e             cause;

    logic               fault_q,  fault_d;
    logic [DATA_W-1:0]  faddr_q,  faddr_d;
    cause_e             fcause_q, fcause_d;

    assign en   = MEM_RAM_CTRL_in[CTRL_E];
    assign rw   = MEM_RAM_CTRL_in[CTRL_RW];
    assign size = size_e'(MEM_RAM_CTRL_in[CTRL_SIZE_HI:CTRL_SIZE_LO]);
    assign widx = MEM_ALU_OUT_in[ADDR_BITS-1:2];

    // Every access sits inside one aligned word, so only that word is read.
    assign ld_word = {mem_q[{widx, 2'd0}], mem_q[{widx, 2'd1}],
                      mem_q[{widx, 2'd2}], mem_q[{widx, 2'd3}]};

    dmem_lane_align u_lane_align (
        .size_i     (size),
        .offs_i     (MEM_ALU_OUT_in[1:0]),
        .st_data_i  (MEM_RB_in),
        .ld_word_i  (ld_word),
        .be_o       (be),
        .st_lanes_o (st_lanes),
        .ld_data_o  (ld_data),
        .misalign_o (misalign),
        .rsvd_o     (rsvd)
    );

    // An aligned access with zero upper bits cannot run past the array end,
    // so a misaligned one near the top is reported as misaligned.
    assign out_of_range = |MEM_ALU_OUT_in[DATA_W-1:ADDR_BITS];
    assign illegal      = rsvd | out_of_range | misalign;
    assign legal        = en & ~illegal;

    always_comb begin
        cause = FC_NONE;
        if (rsvd)              cause = FC_SIZE;
        else if (out_of_range) cause = FC_RANGE;
        else if (misalign)     cause = FC_MISALIGN;
    end

    assign MEM_DATA_out = (legal && !rw) ? ld_data : '0;

    always_ff @(posedge clk) begin
        if (!Reset && legal && rw) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (be[k]) begin
                    mem_q[{widx, 2'(LANES - 1 - k)}] <= st_lanes[8*k +: 8];
                end
            end
        end
    end

    // First-fault capture; later faults are ignored until reset.
    always_comb begin
        fault_d  = fault_q;
        faddr_d  = faddr_q;
        fcause_d = fcause_q;
        if (en && illegal && !fault_q) begin
            fault_d  = 1'b1;
            faddr_d  = MEM_ALU_OUT_in;
            fcause_d = cause;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            fault_q  <= 1'b0;
            faddr_q  <= '0;
            fcause_q <= FC_NONE;
        end else begin
            fault_q  <= fault_d;
            faddr_q  <= faddr_d;
            fcause_q <= fcause_d;
        end
    end

    assign MEM_FAULT_out       = fault_q;
    assign MEM_FAULT_ADDR_out  = faddr_q;
    assign MEM_FAULT_CAUSE_out = fcause_q;

endmodule
